// File: rtl/scan_decoder_nx_if.sv
// Select/one-hot bus between a controller (master) and scan_decoder_nx (slave).
interface scan_decoder_nx_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned OUT_W = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel;
  logic               sel_ready;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic               y_valid;
  logic               scan_wrap;

  modport master (
    output en, mode, sel_valid, sel, dwell,
    input  sel_ready, y, y_valid, scan_wrap
  );

  modport slave (
    input  en, mode, sel_valid, sel, dwell,
    output sel_ready, y, y_valid, scan_wrap
  );
endinterface

// File: rtl/scan_decoder_nx.sv
// Registered N-to-2^N one-hot decoder with handshake decode mode and an optional
// scan mode that walks the output through every line; scan is built only with SCAN_DECODER_SCAN_EN.
module scan_decoder_nx #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned OUT_W   = 1 << SEL_W,
  parameter int unsigned DWELL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  scan_decoder_nx_if.slave bus
);

`ifdef SCAN_DECODER_SCAN_EN
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SCAN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DECODE} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_y;
  logic [OUT_W-1:0]   w_y_nxt;
  logic               r_y_valid;
  logic               w_y_valid_nxt;
  logic               r_pend;
  logic               w_pend_nxt;
  logic [SEL_W-1:0]   r_pend_sel;
  logic [SEL_W-1:0]   w_pend_sel_nxt;
  logic               w_accept;

`ifdef SCAN_DECODER_SCAN_EN
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;

  assign bus.sel_ready = bus.en & ~bus.mode;
  assign bus.scan_wrap = r_wrap;
`else
  logic               w_unused_inputs;

  assign bus.sel_ready   = bus.en;
  assign bus.scan_wrap   = 1'b0;
  assign w_unused_inputs = ^{bus.mode, bus.dwell};
`endif

  assign w_accept    = bus.sel_valid & bus.sel_ready;
  assign bus.y       = r_y;
  assign bus.y_valid = r_y_valid;

  // Next-state and output decode. An accept taken while not yet in DECODE is
  // held for one cycle and applied at the following edge unless a newer one arrives.
  always_comb begin
    w_state_nxt    = r_state;
    w_y_nxt        = r_y;
    w_y_valid_nxt  = r_y_valid;
    w_pend_nxt     = 1'b0;
    w_pend_sel_nxt = r_pend_sel;
`ifdef SCAN_DECODER_SCAN_EN
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_wrap_nxt     = 1'b0;
`endif
    if (!bus.en) begin
      w_state_nxt   = S_IDLE;
      w_y_nxt       = '0;
      w_y_valid_nxt = 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
      w_idx_nxt     = '0;
      w_cnt_nxt     = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_DECODE;
          if (w_accept) begin
            w_pend_nxt     = 1'b1;
            w_pend_sel_nxt = bus.sel;
          end
`ifdef SCAN_DECODER_SCAN_EN
          if (bus.mode) begin
            w_state_nxt   = S_SCAN;
            w_y_nxt       = OUT_W'(1);
            w_y_valid_nxt = 1'b1;
            w_idx_nxt     = '0;
            w_cnt_nxt     = bus.dwell;
          end
`endif
        end

        S_DECODE: begin
`ifdef SCAN_DECODER_SCAN_EN
          if (bus.mode) begin
            w_state_nxt   = S_SCAN;
            w_y_nxt       = OUT_W'(1);
            w_y_valid_nxt = 1'b1;
            w_idx_nxt     = '0;
            w_cnt_nxt     = bus.dwell;
          end else
`endif
          if (w_accept) begin
            w_y_nxt       = OUT_W'(1) << bus.sel;
            w_y_valid_nxt = 1'b1;
          end else if (r_pend) begin
            w_y_nxt       = OUT_W'(1) << r_pend_sel;
            w_y_valid_nxt = 1'b1;
          end
        end

`ifdef SCAN_DECODER_SCAN_EN
        S_SCAN: begin
          if (!bus.mode) begin
            w_state_nxt   = S_DECODE;
            w_y_nxt       = '0;
            w_y_valid_nxt = 1'b0;
            w_idx_nxt     = '0;
            w_cnt_nxt     = '0;
            if (w_accept) begin
              w_pend_nxt     = 1'b1;
              w_pend_sel_nxt = bus.sel;
            end
          end else if (r_cnt == '0) begin
            // Line expired: advance (wrapping naturally at 2^SEL_W) and reload dwell.
            w_idx_nxt     = SEL_W'(r_idx + 1'b1);
            w_cnt_nxt     = bus.dwell;
            w_y_nxt       = OUT_W'(1) << SEL_W'(r_idx + 1'b1);
            w_y_valid_nxt = 1'b1;
            w_wrap_nxt    = &r_idx;
          end else begin
            w_cnt_nxt = DWELL_W'(r_cnt - 1'b1);
          end
        end
`endif

        default: begin
          w_state_nxt   = S_IDLE;
          w_y_nxt       = '0;
          w_y_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_sel <= '0;
`ifdef SCAN_DECODER_SCAN_EN
      r_idx      <= '0;
      r_cnt      <= '0;
      r_wrap     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_y        <= w_y_nxt;
      r_y_valid  <= w_y_valid_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_sel <= w_pend_sel_nxt;
`ifdef SCAN_DECODER_SCAN_EN
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wrap     <= w_wrap_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_scan_decoder_nx.sv
// Scoreboard bench for scan_decoder_nx (SEL_W=3); scan scenarios run when SCAN_DECODER_SCAN_EN is defined.
module tb_scan_decoder_nx;

  typedef struct packed {
    logic [7:0] y;
    logic       yv;
    logic       wr;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  scan_decoder_nx_if #(.SEL_W(3), .DWELL_W(8)) bus ();

  scan_decoder_nx #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] y, input logic wr);
    mk = {y, (y != 8'h00), wr};
  endfunction

  task automatic drive(input logic en, input logic mode, input logic sv,
                       input logic [2:0] sel, input logic [7:0] dw);
    bus.en        = en;
    bus.mode      = mode;
    bus.sel_valid = sv;
    bus.sel       = sel;
    bus.dwell     = dw;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'd3, 8'd0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.y, bus.y_valid, bus.scan_wrap} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got y=%h v=%b wrap=%b want all zero", bus.y, bus.y_valid, bus.scan_wrap);
    end
    n_cmp++;
`ifdef SCAN_DECODER_SCAN_EN
    if (bus.sel_ready !== 1'b0) begin
`else
    if (bus.sel_ready !== 1'b1) begin
`endif
      n_err++;
      $display("FAIL reset_ready_mode1: got sel_ready=%b", bus.sel_ready);
    end
    drive(1'b1, 1'b0, 1'b1, 3'd5, 8'd0);
    #1;
    n_cmp++;
    if (bus.sel_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_mode0: got sel_ready=%b want 1", bus.sel_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.y, bus.y_valid} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_no_accept: got y=%h v=%b want y=00 v=0", bus.y, bus.y_valid);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    @(negedge clk);
    n_cmp++;
    if ({bus.y, bus.y_valid, bus.scan_wrap} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_release: got y=%h v=%b wrap=%b want all zero", bus.y, bus.y_valid, bus.scan_wrap);
    end
  endtask

  task automatic test_decode;
    exp_t       e;
    logic [2:0] sels [3];
    sels[0] = 3'b000; sels[1] = 3'b101; sels[2] = 3'b010;
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL decode step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      if (s == 0) begin
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        sb.push_back(mk(8'h00, 1'b0));
      end else if (s <= 3) begin
        drive(1'b1, 1'b0, 1'b1, sels[s-1], 8'd0);
        #1;
        n_cmp++;
        if (bus.sel_ready !== 1'b1) begin
          n_err++;
          $display("FAIL decode_ready step %0d: got sel_ready=%b want 1", s, bus.sel_ready);
        end
        sb.push_back(mk(8'h01 << sels[s-1], 1'b0));
      end else begin
        drive(1'b1, 1'b0, 1'b0, 3'd7, 8'd0);
        sb.push_back(mk(8'h04, 1'b0));
      end
    end
  endtask

  task automatic test_enable;
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL enable step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      case (s)
        0: begin
          drive(1'b0, 1'b0, 1'b1, 3'd7, 8'd0);
          #1;
          n_cmp++;
          if (bus.sel_ready !== 1'b0) begin
            n_err++;
            $display("FAIL enable_ready: got sel_ready=%b want 0", bus.sel_ready);
          end
          sb.push_back(mk(8'h00, 1'b0));
        end
        1: begin drive(1'b0, 1'b0, 1'b1, 3'd1, 8'd0); sb.push_back(mk(8'h00, 1'b0)); end
        2: begin drive(1'b1, 1'b0, 1'b0, 3'd0, 8'd0); sb.push_back(mk(8'h00, 1'b0)); end
        3: begin drive(1'b1, 1'b0, 1'b1, 3'd7, 8'd0); sb.push_back(mk(8'h80, 1'b0)); end
        default: begin drive(1'b1, 1'b0, 1'b0, 3'd2, 8'd0); sb.push_back(mk(8'h80, 1'b0)); end
      endcase
    end
  endtask

`ifdef SCAN_DECODER_SCAN_EN
  task automatic test_scan_dwell0;
    exp_t e;
    int   line;
    for (int s = 0; s <= 20; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL scan_dwell0 step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      drive(1'b1, 1'b1, (s == 0), 3'd3, 8'd0);
      if (s == 0) begin
        #1;
        n_cmp++;
        if (bus.sel_ready !== 1'b0) begin
          n_err++;
          $display("FAIL scan_ready: got sel_ready=%b want 0", bus.sel_ready);
        end
      end
      line = s % 8;
      sb.push_back(mk(8'(1 << line), (s > 0) && (line == 0)));
    end
  endtask

  task automatic test_mode_switch;
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL mode_switch step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      drive(1'b1, 1'b0, (s < 2), 3'b111, 8'd0);
      if (s == 0) sb.push_back(mk(8'h00, 1'b0));
      else        sb.push_back(mk(8'h80, 1'b0));
    end
  endtask

  task automatic test_scan_dwell2;
    exp_t e;
    int   line;
    logic wr;
    for (int s = 0; s <= 62; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL scan_dwell2 step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      // dwell drops to 0 in the middle of line 1; that line still lasts 3 cycles
      drive(1'b1, 1'b1, 1'b0, 3'd0, (s >= 52) ? 8'd0 : 8'd2);
      if (s <= 53) begin
        line = (s / 3) % 8;
        wr   = (s > 0) && (s % 3 == 0) && (line == 0);
      end else begin
        line = (2 + (s - 54)) % 8;
        wr   = (line == 0);
      end
      sb.push_back(mk(8'(1 << line), wr));
    end
  endtask

  task automatic test_en_midscan;
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL en_midscan step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      case (s)
        0, 1: begin
          drive(1'b0, 1'b0, 1'b1, 3'd2, 8'd0);
          #1;
          n_cmp++;
          if (bus.sel_ready !== 1'b0) begin
            n_err++;
            $display("FAIL en_midscan_ready: got sel_ready=%b want 0", bus.sel_ready);
          end
          sb.push_back(mk(8'h00, 1'b0));
        end
        2: begin drive(1'b1, 1'b1, 1'b0, 3'd0, 8'd0); sb.push_back(mk(8'h01, 1'b0)); end
        3: begin drive(1'b1, 1'b1, 1'b0, 3'd0, 8'd0); sb.push_back(mk(8'h02, 1'b0)); end
        default: begin drive(1'b0, 1'b1, 1'b0, 3'd0, 8'd0); sb.push_back(mk(8'h00, 1'b0)); end
      endcase
    end
  endtask
`else
  task automatic test_macro_off;
    exp_t e;
    for (int s = 0; s < 11; s++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
          n_err++;
          $display("FAIL macro_off step %0d: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                   s, bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
        end
      end
      drive(1'b1, 1'b1, (s == 0), 3'b110, 8'd0);
      if (s == 0) begin
        #1;
        n_cmp++;
        if (bus.sel_ready !== 1'b1) begin
          n_err++;
          $display("FAIL macro_off_ready: got sel_ready=%b want 1", bus.sel_ready);
        end
      end
      sb.push_back(mk(8'h40, 1'b0));
    end
  endtask
`endif

  initial begin
    exp_t e;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    test_reset;
    test_decode;
    test_enable;
`ifdef SCAN_DECODER_SCAN_EN
    test_scan_dwell0;
    test_mode_switch;
    test_scan_dwell2;
    test_en_midscan;
`else
    test_macro_off;
`endif
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.y, bus.y_valid, bus.scan_wrap} !== e) begin
        n_err++;
        $display("FAIL drain: got y=%h v=%b wrap=%b want y=%h v=%b wrap=%b",
                 bus.y, bus.y_valid, bus.scan_wrap, e.y, e.yv, e.wr);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_decoder_nx.md
# scan_decoder_nx

Parametrised, registered N-to-2^N one-hot decoder; the sequential successor to the team's fixed 3-to-8 combinational decoder. Drives one-hot select lines (bank enables, LED/column strobes) from a registered output. In decode mode it latches a select index through a valid/ready handshake. In scan mode it steps a one-hot output through every line, holding each line for a programmable number of cycles.

## Interface
Parameters:
- SEL_W, 3, select index width
- OUT_W, 1<<SEL_W, one-hot output width; fixed as 2^SEL_W, never overridden
- DWELL_W, 8, width of the per-line hold count

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  block enable; 0 forces idle
- mode  input  1  0 = decode, 1 = scan
- sel_valid  input  1  sel is valid this cycle
- sel  input  SEL_W  index to decode
- sel_ready  output  1  combinational: en & ~mode (scan mode present), else en
- dwell  input  DWELL_W  extra hold cycles per scan line
- y  output  OUT_W  registered one-hot (or all-zero) output
- y_valid  output  1  registered: y holds a live selection
- scan_wrap  output  1  registered one-cycle pulse when the scan returns to line 0

## Operation
- States: IDLE, DECODE, SCAN. Reset and en=0 both go to IDLE.
- Reset values: y=0, y_valid=0, scan_wrap=0, line index=0, dwell counter=0, state IDLE.
- IDLE:
  - en=1, mode=0 -> DECODE, y unchanged at 0.
  - en=1, mode=1 -> SCAN.
- DECODE:
  - Accept occurs on sel_valid & sel_ready. The next edge sets y = 1<<sel and y_valid=1.
  - y holds until the next accept. Back-to-back accepts update y every cycle.
  - sel_valid while sel_ready=0 is ignored; no buffering.
- SCAN:
  - On entry, the next edge sets y = 1<<0, y_valid=1, index=0, and loads the counter with dwell.
  - Counter decrements each cycle. When it is 0, index advances by 1 and the counter reloads from the current dwell, sampled at that edge.
  - Each line is therefore held dwell+1 cycles; dwell=0 advances every cycle.
  - Index OUT_W-1 wraps to 0. scan_wrap=1 for exactly the cycle in which y first returns to bit 0 after a wrap. There is no pulse on initial entry.
- Mode change:
  - SCAN -> mode=0: the next edge sets y=0, y_valid=0 and enters DECODE. Any sel accepted in that same cycle is decoded at the following edge.
  - DECODE -> mode=1: SCAN restarts at index 0. A sel presented in the same cycle is not accepted, because sel_ready is already 0.
- en=0 from any state: the next edge clears y, y_valid, scan_wrap, index and counter, and enters IDLE.
- Priority: rst > en=0 > mode change > accept/step.
- Invariant: y is always 0 or exactly one bit set. y_valid == (y != 0).

## Timing
- Decode latency: 1 cycle from an accepting edge to y/y_valid.
- Scan entry: y=1 one cycle after en & mode are first seen high in IDLE or DECODE.
- Scan period: OUT_W*(dwell+1) cycles when dwell is held constant.
- All outputs except sel_ready are registered. sel_ready has no register stage.
- Reset mid-scan or mid-decode: outputs equal reset values the cycle after the rst edge. While rst=1, sel_ready follows en/mode, but no accept takes effect.

## Configuration
- Macro: SCAN_DECODER_SCAN_EN.
- Defined: full behaviour above; states IDLE/DECODE/SCAN.
- Undefined:
  - SCAN state, dwell counter, index logic and scan_wrap generation are not compiled.
  - mode and dwell inputs are ignored.
  - scan_wrap is tied to 0.
  - sel_ready = en.
  - The block is a pure registered handshake decoder with the same 1-cycle latency.

## Test plan
- Reset: assert rst 2 cycles with en=1, mode=1 -> y=8'h00, y_valid=0, scan_wrap=0 after release edge.
- Decode (SEL_W=3), accepts back-to-back:
  - sel=3'b000, 3'b101, 3'b010 on consecutive cycles, sel_valid=1, mode=0 -> y=8'h01, 8'h20, 8'h04 one cycle later each, y_valid=1.
  - Then sel_valid=0 for 5 cycles -> y stays 8'h04.
- Scan, dwell=0:
  - mode=1 -> y walks 8'h01,02,04,...,80,01.
  - scan_wrap=1 only in the cycle y returns to 8'h01 (cycle 9 after entry), period 8 cycles.
- Scan, dwell=2: each line is held 3 cycles, so the wrap pulse repeats every 24 cycles.
  - Change dwell to 0 mid-line -> the new value applies at the next reload only.
- Mode/enable switches:
  - Mode 1->0 while y=8'h10 -> next cycle y=8'h00, y_valid=0. A sel=3'b111 accept in the same cycle -> y=8'h80 one cycle later.
  - en=0 mid-scan -> y=0 next cycle; sel_valid with en=0 sees sel_ready=0 and is not accepted.
- Macro off: mode=1, sel=3'b110 valid -> sel_ready=1, y=8'h40 one cycle later; scan_wrap never asserts.
